mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised modulo-N up/down counter with synchronous clear, parallel load and compare.
- Selectable free-running (wrap) or one-shot (stop at terminal) mode.
- Successor to the plain binary enable-chain counter; used for timers, baud and prescale dividers, and event counting.
- Terminal-count output (tc) can cascade into the next stage's ena.

Parameters:
- BITS, 8: counter width.
- MODULUS, 2**BITS: count range is 0..MODULUS-1. Legal range is 2..2**BITS; anything else is an elaboration error via a generate-time check.
- ONE_SHOT, 0: 0 = wrap at terminal; 1 = hold at terminal and assert done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ena  in  1  count enable, one step per enabled cycle.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  BITS  value loaded when load=1.
- dir  in  1  1 = count up, 0 = count down.
- cmp_val  in  BITS  compare value.
- out  out  BITS  current count (register).
- tc  out  1  terminal count, combinational.
- match  out  1  registered compare hit.
- done  out  1  one-shot finished, sticky (always 0 when ONE_SHOT=0).

Behaviour:
- Reset (rst=0, asynchronous): out=0, match=0, done=0. These values hold while rst is low. Deassertion takes effect at the next clk edge.
- Terminal value:
  - up: MODULUS-1.
  - down: 0.
  - at_term = (out == terminal for the current dir).
- tc = ena & at_term & ~clr & ~load & ~done. Purely combinational, same-cycle, no register; it feeds a cascaded stage's ena.
- Per rising clk, priority is clr > load > ena.
- clr=1:
  - out <= 0, done <= 0.
  - load and ena are ignored.
- load=1 (clr=0):
  - out <= min(load_val, MODULUS-1), i.e. clamped.
  - done <= 0.
  - ena is ignored that cycle.
- ena=1 with no clr/load, and done=0:
  - up: out <= (out==MODULUS-1) ? 0 : out+1.
  - down: out <= (out==0) ? MODULUS-1 : out-1.
  - ONE_SHOT=1 and at_term: out holds, done <= 1 (the wrap is suppressed).
- ena=1 and done=1: out holds, no tc. Only clr or load (or reset) re-arms the counter.
- ena=0: out holds.
- dir may change on any cycle and takes effect on the same edge. Changing dir at the terminal value is not special: the new-direction terminal applies.
- match <= (next value of out == cmp_val), registered, so it is aligned with out. match=1 exactly while out==cmp_val, updated on every edge including load and clr. cmp_val >= MODULUS never matches.
- Arithmetic is BITS-wide with no overflow beyond MODULUS-1. MODULUS=2**BITS must synthesise to natural wrap without a comparator-induced bug, i.e. the terminal constant is computed at BITS width.

Decomposition:
- Shared package counter_pkg holds:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Function clog2 for users sizing BITS from MODULUS.
- No sub-module. The next-value logic is a single always block plus tc/match assigns.
- Cascading multiple instances is done at the instantiation level through tc -> ena.

Test Plan:
- BITS=4, MODULUS=10, ONE_SHOT=0, dir=1, ena=1 for 12 cycles from reset -> out 1..9,0,1,2; tc high exactly in the cycle out=9; match with cmp_val=3 high when out=3.
- Same config, dir=0 from out=0 -> next out=9, tc high during out=0; toggle dir at out=5 -> next out=6 (up) or 4 (down) per new dir.
- ONE_SHOT=1, MODULUS=10, load_val=7, load then ena up -> out 8,9, then holds 9; done=1 after the edge at 9; tc high one cycle only; load_val=2 -> done=0, out=2.
- Priority: clr=1, load=1, ena=1 with load_val=5 -> out=0; load=1, ena=1 -> out=5 (no increment); load_val=15 with MODULUS=10 -> out=9.
- Assert rst low mid-count (out=6) between clock edges -> out=0, match=0, done=0 immediately; counting resumes from 0 after release.
- Two cascaded instances BITS=4, MODULUS=16 (low.tc -> high.ena) for 300 cycles -> {high,low} equals cycle count mod 256; high.tc asserted only at 255.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encoding and a
// width helper for callers that size BITS from a modulus.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Smallest width w such that 2**w >= value.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clear, clamped load, compare and one-shot mode.
// tc is combinational so it can drive the ena of a cascaded stage.
module mod_counter
   import counter_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int MODULUS  = 2 ** BITS,
   parameter int ONE_SHOT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            clr,
   input  logic            load,
   input  logic [BITS-1:0] load_val,
   input  logic            dir,
   input  logic [BITS-1:0] cmp_val,
   output logic [BITS-1:0] out,
   output logic            tc,
   output logic            match,
   output logic            done
);

   generate
      if (MODULUS < 2 || MODULUS > 2 ** BITS) begin : g_bad_modulus
         $error("mod_counter: MODULUS must lie in 2..2**BITS");
      end
   endgenerate

   // Sized at BITS so MODULUS == 2**BITS gives an all-ones terminal, not an overflow.
   localparam logic [BITS-1:0] TERM_UP = BITS'(MODULUS - 1);

   logic [BITS-1:0] out_nxt;
   logic            done_nxt;
   logic            at_term;

   assign at_term = (dir == DIR_UP) ? (out == TERM_UP) : (out == '0);
   assign tc      = ena & at_term & ~clr & ~load & ~done;

   always_comb begin
      out_nxt  = out;
      done_nxt = done;
      if (clr) begin
         out_nxt  = '0;
         done_nxt = 1'b0;
      end else if (load) begin
         out_nxt  = (load_val > TERM_UP) ? TERM_UP : load_val;
         done_nxt = 1'b0;
      end else if (ena && !done) begin
         if (ONE_SHOT != 0 && at_term) begin
            done_nxt = 1'b1;
         end else if (dir == DIR_UP) begin
            out_nxt = at_term ? '0 : out + 1'b1;
         end else begin
            out_nxt = at_term ? TERM_UP : out - 1'b1;
         end
      end
   end

   // match compares the value being registered so it lines up with out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out   <= '0;
         match <= 1'b0;
         done  <= 1'b0;
      end else begin
         out   <= out_nxt;
         match <= (out_nxt == cmp_val);
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: decimal, one-shot, full-width and a two-stage cascade,
// all checked each cycle against an arithmetic reference model.
module tb_mod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena, clr, load, dir;
   logic [7:0] lv, cmp;

   logic [3:0] out_dec, out_os, out_lo, out_hi;
   logic [7:0] out_wide;
   logic       tc_dec, tc_os, tc_wide, tc_lo, tc_hi;
   logic       match_dec, match_os, match_wide, match_lo, match_hi;
   logic       done_dec, done_os, done_wide, done_lo, done_hi;

   always #5 clk = ~clk;

   mod_counter #(.BITS(4), .MODULUS(10), .ONE_SHOT(0)) u_dec (
      .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(lv[3:0]),
      .dir(dir), .cmp_val(cmp[3:0]), .out(out_dec), .tc(tc_dec), .match(match_dec),
      .done(done_dec));

   mod_counter #(.BITS(4), .MODULUS(10), .ONE_SHOT(1)) u_os (
      .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(lv[3:0]),
      .dir(dir), .cmp_val(cmp[3:0]), .out(out_os), .tc(tc_os), .match(match_os),
      .done(done_os));

   mod_counter #(.BITS(8)) u_wide (
      .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(lv),
      .dir(dir), .cmp_val(cmp), .out(out_wide), .tc(tc_wide), .match(match_wide),
      .done(done_wide));

   mod_counter #(.BITS(4), .MODULUS(16), .ONE_SHOT(0)) u_lo (
      .clk(clk), .rst(rst), .ena(1'b1), .clr(1'b0), .load(1'b0), .load_val(4'd0),
      .dir(1'b1), .cmp_val(4'd0), .out(out_lo), .tc(tc_lo), .match(match_lo),
      .done(done_lo));

   mod_counter #(.BITS(4), .MODULUS(16), .ONE_SHOT(0)) u_hi (
      .clk(clk), .rst(rst), .ena(tc_lo), .clr(1'b0), .load(1'b0), .load_val(4'd0),
      .dir(1'b1), .cmp_val(4'd0), .out(out_hi), .tc(tc_hi), .match(match_hi),
      .done(done_hi));

   // Reference model: one entry per independently driven instance.
   localparam int MODS [3] = '{10, 10, 256};
   localparam int WIDS [3] = '{4, 4, 8};
   localparam bit OSS  [3] = '{1'b0, 1'b1, 1'b0};

   int m_cnt   [3];
   bit m_done  [3];
   bit m_match [3];
   int casc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_tc(input int i);
      int term;
      term = dir ? MODS[i] - 1 : 0;
      return ena && (m_cnt[i] == term) && !clr && !load && !m_done[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]   = 0;
         m_done[i]  = 1'b0;
         m_match[i] = 1'b0;
      end
      casc_cnt = 0;
   endtask

   task automatic model_update();
      int mask, lvm, term, c;
      bit d;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         mask = (1 << WIDS[i]) - 1;
         lvm  = int'(lv) & mask;
         term = dir ? MODS[i] - 1 : 0;
         c    = m_cnt[i];
         d    = m_done[i];
         if (clr) begin
            c = 0;
            d = 1'b0;
         end else if (load) begin
            c = (lvm > MODS[i] - 1) ? MODS[i] - 1 : lvm;
            d = 1'b0;
         end else if (ena && !d) begin
            if (OSS[i] && c == term) d = 1'b1;
            else if (dir) c = (c + 1) % MODS[i];
            else c = (c + MODS[i] - 1) % MODS[i];
         end
         m_cnt[i]   = c;
         m_done[i]  = d;
         m_match[i] = (c == (int'(cmp) & mask));
      end
      casc_cnt++;
   endtask

   task automatic check_all();
      logic [7:0] o_out [3];
      logic       o_tc [3], o_match [3], o_done [3];
      o_out   = '{{4'b0, out_dec}, {4'b0, out_os}, out_wide};
      o_tc    = '{tc_dec, tc_os, tc_wide};
      o_match = '{match_dec, match_os, match_wide};
      o_done  = '{done_dec, done_os, done_wide};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out[%0d]", i), 32'(o_out[i]), 32'(m_cnt[i]));
         chk($sformatf("tc[%0d]", i), 32'(o_tc[i]), 32'(model_tc(i)));
         chk($sformatf("match[%0d]", i), 32'(o_match[i]), 32'(m_match[i]));
         chk($sformatf("done[%0d]", i), 32'(o_done[i]), 32'(m_done[i]));
      end
      chk("casc_val", 32'({out_hi, out_lo}), 32'(casc_cnt % 256));
      chk("casc_lo_tc", 32'(tc_lo), 32'((casc_cnt % 16) == 15));
      chk("casc_hi_tc", 32'(tc_hi), 32'((casc_cnt % 256) == 255));
   endtask

   // Inputs are set right after a falling edge; outputs are checked 1 ns later.
   task automatic step();
      #1 check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      ena = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1; lv = '0; cmp = 8'd3;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      step();
      rst = 1'b1;

      // Free-running up count from reset
      ena = 1'b1;
      repeat (12) step();
      chk("up12_out", 32'(out_dec), 32'd2);
      chk("up12_os_done", 32'(done_os), 32'd1);

      // Down count wraps 0 -> 9, then direction change at 5
      clr = 1'b1; step();
      clr = 1'b0; dir = 1'b0;
      #1 chk("down_tc_at0", 32'(tc_dec), 32'd1);
      step();
      chk("down_wrap", 32'(out_dec), 32'd9);
      repeat (4) step();
      chk("down_at5", 32'(out_dec), 32'd5);
      dir = 1'b1; step();
      chk("dir_up_from5", 32'(out_dec), 32'd6);
      dir = 1'b0; step();
      chk("dir_down_from6", 32'(out_dec), 32'd5);

      // One-shot: load 7, count to 9 and stick
      load = 1'b1; lv = 8'd7; dir = 1'b1; ena = 1'b0; step();
      load = 1'b0; ena = 1'b1;
      step(); step();
      chk("os_at9", 32'(out_os), 32'd9);
      chk("os_not_done", 32'(done_os), 32'd0);
      #1 chk("os_tc_at9", 32'(tc_os), 32'd1);
      step();
      chk("os_hold9", 32'(out_os), 32'd9);
      chk("os_done", 32'(done_os), 32'd1);
      #1 chk("os_tc_after_done", 32'(tc_os), 32'd0);
      step();
      chk("os_still9", 32'(out_os), 32'd9);
      load = 1'b1; lv = 8'd2; step();
      chk("os_reload", 32'(out_os), 32'd2);
      chk("os_rearm", 32'(done_os), 32'd0);

      // Priority clr > load > ena, load clamping
      clr = 1'b1; load = 1'b1; ena = 1'b1; lv = 8'd5; step();
      chk("prio_clr", 32'(out_dec), 32'd0);
      clr = 1'b0; step();
      chk("prio_load", 32'(out_dec), 32'd5);
      lv = 8'd15; step();
      chk("load_clamp", 32'(out_dec), 32'd9);
      chk("load_wide15", 32'(out_wide), 32'd15);
      load = 1'b0;

      // Asynchronous reset between edges
      clr = 1'b1; step();
      clr = 1'b0; dir = 1'b1; cmp = 8'd6;
      repeat (6) step();
      chk("pre_rst_out", 32'(out_dec), 32'd6);
      chk("pre_rst_match", 32'(match_dec), 32'd1);
      #2 rst = 1'b0;
      model_reset();
      #1 chk("rst_out", 32'(out_dec), 32'd0);
      chk("rst_match", 32'(match_dec), 32'd0);
      chk("rst_done", 32'(done_os), 32'd0);
      check_all();
      @(negedge clk);
      step();
      rst = 1'b1;
      step();
      chk("post_rst_out", 32'(out_dec), 32'd1);

      // Randomized traffic
      repeat (400) begin
         clr  = ($urandom_range(0, 15) == 0);
         load = ($urandom_range(0, 7) == 0);
         ena  = ($urandom_range(0, 3) != 0);
         dir  = 1'($urandom_range(0, 1));
         lv   = 8'($urandom_range(0, 255));
         cmp  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15))
                                            : 8'($urandom_range(0, 255));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
